// File: rtl/pr3_frame_sink.sv
// pr3_frame_sink
//   Receiving end of the PR3 spectrum output stream. Checks sop/eop framing,
//   captures complete frames of 2**FFT words into a two-bank ping-pong buffer
//   and exposes the oldest buffered frame through a registered random-access
//   read port. Malformed frames and frames arriving while both banks are full
//   are dropped and counted; the source is never stalled.
//
// Ports
//   clk40, reset_n   clock, asynchronous active-low reset
//   sink_valid/sop/eop/data   input stream (sop/eop qualified by sink_valid)
//   frame_ready      read bank holds a complete frame
//   frame_ack        one-cycle pulse releasing the read bank
//   rd_addr/rd_data  word read from the read bank, 1-cycle latency
//   frame_count      committed frames (wraps)
//   err_count        framing errors + overruns (saturates)
//   overrun          sticky, set when a frame is dropped for lack of a bank
//
// Optional feature (macro PR3_SINK_PEAK_EN): adds peak_index/peak_value,
//   the position and value of the first unsigned maximum of each frame,
//   reported for the read bank.
module pr3_frame_sink #(
  parameter int FFT = 11,
  parameter int DW  = 32,
  parameter int CW  = 16
) (
  input  logic           clk40,
  input  logic           reset_n,
  input  logic           sink_valid,
  input  logic           sink_sop,
  input  logic           sink_eop,
  input  logic [DW-1:0]  sink_data,
  output logic           frame_ready,
  input  logic           frame_ack,
  input  logic [FFT-1:0] rd_addr,
  output logic [DW-1:0]  rd_data,
  output logic [CW-1:0]  frame_count,
  output logic [CW-1:0]  err_count,
  output logic           overrun
`ifdef PR3_SINK_PEAK_EN
  ,
  output logic [FFT-1:0] peak_index,
  output logic [DW-1:0]  peak_value
`endif
);

  localparam int LEN = 1 << FFT;
  localparam logic [FFT-1:0] LAST = FFT'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [FFT-1:0] cnt, cnt_n;
  logic [1:0]     full, full_n;
  logic           wb, wb_n, rb, rb_n;
  logic           we, commit, start, err_inc, ovr_set;
  logic [FFT-1:0] waddr;
  logic [DW-1:0]  mem [0:2*LEN-1];

  // Framing FSM: decides what to do with each accepted word.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we      = 1'b0;
    waddr   = cnt;
    commit  = 1'b0;
    start   = 1'b0;
    err_inc = 1'b0;
    ovr_set = 1'b0;
    if (sink_valid) begin
      if (sink_sop) begin
        // A sop always starts a new frame; an open frame is abandoned.
        if (state == RECV) begin
          err_inc = 1'b1;
        end else begin
          err_inc = err_inc;
        end
        if (full[wb]) begin
          err_inc = 1'b1;
          ovr_set = 1'b1;
          state_n = sink_eop ? IDLE : DROP;
        end else if (sink_eop) begin
          err_inc = 1'b1;
          state_n = IDLE;
        end else begin
          we      = 1'b1;
          waddr   = {FFT{1'b0}};
          cnt_n   = FFT'(1);
          start   = 1'b1;
          state_n = RECV;
        end
      end else begin
        case (state)
          IDLE: begin
            err_inc = 1'b1;
            state_n = IDLE;
          end
          RECV: begin
            if (sink_eop) begin
              if (cnt == LAST) begin
                we     = 1'b1;
                commit = 1'b1;
              end else begin
                err_inc = 1'b1;
              end
              state_n = IDLE;
            end else if (cnt == LAST) begin
              err_inc = 1'b1;
              state_n = DROP;
            end else begin
              we    = 1'b1;
              cnt_n = cnt + FFT'(1);
            end
          end
          DROP: begin
            if (sink_eop) begin
              state_n = IDLE;
            end else begin
              state_n = DROP;
            end
          end
          default: begin
            state_n = IDLE;
          end
        endcase
      end
    end else begin
      state_n = state;
    end
  end

  // Bank bookkeeping: commit fills the write bank, ack frees the read bank.
  // A commit and a valid ack never address the same bank.
  always_comb begin
    full_n = full;
    wb_n   = wb;
    rb_n   = rb;
    if (commit) begin
      full_n[wb] = 1'b1;
      wb_n       = ~wb;
    end else begin
      wb_n = wb;
    end
    if (frame_ack && full[rb]) begin
      full_n[rb] = 1'b0;
      rb_n       = ~rb;
    end else begin
      rb_n = rb;
    end
  end

  // Control state, counters and status outputs.
  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= {FFT{1'b0}};
      full        <= 2'b00;
      wb          <= 1'b0;
      rb          <= 1'b0;
      frame_ready <= 1'b0;
      frame_count <= {CW{1'b0}};
      err_count   <= {CW{1'b0}};
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      full        <= full_n;
      wb          <= wb_n;
      rb          <= rb_n;
      frame_ready <= full_n[rb_n];
      if (commit) begin
        frame_count <= frame_count + CW'(1);
      end
      if (err_inc && (err_count != {CW{1'b1}})) begin
        err_count <= err_count + CW'(1);
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

  // Frame storage; bank select is the top address bit.
  always_ff @(posedge clk40) begin
    if (we) begin
      mem[{wb, waddr}] <= sink_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= {DW{1'b0}};
    end else begin
      rd_data <= mem[{rb, rd_addr}];
    end
  end

`ifdef PR3_SINK_PEAK_EN
  logic [DW-1:0]  cur_max, run_max;
  logic [FFT-1:0] cur_idx, run_idx;
  logic [DW-1:0]  pk_val [0:1];
  logic [FFT-1:0] pk_idx [0:1];

  // Running maximum including the current word; strict compare keeps the first peak.
  always_comb begin
    run_max = cur_max;
    run_idx = cur_idx;
    if (start) begin
      run_max = sink_data;
      run_idx = {FFT{1'b0}};
    end else if (sink_data > cur_max) begin
      run_max = sink_data;
      run_idx = cnt;
    end else begin
      run_max = cur_max;
      run_idx = cur_idx;
    end
  end

  // Peak tracking and per-bank capture at commit.
  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      cur_max   <= {DW{1'b0}};
      cur_idx   <= {FFT{1'b0}};
      pk_val[0] <= {DW{1'b0}};
      pk_val[1] <= {DW{1'b0}};
      pk_idx[0] <= {FFT{1'b0}};
      pk_idx[1] <= {FFT{1'b0}};
    end else begin
      if (we) begin
        cur_max <= run_max;
        cur_idx <= run_idx;
      end
      if (commit) begin
        pk_val[wb] <= run_max;
        pk_idx[wb] <= run_idx;
      end
    end
  end

  assign peak_index = pk_idx[rb];
  assign peak_value = pk_val[rb];
`endif

endmodule

// File: tb/tb_pr3_frame_sink.sv
// Bench for pr3_frame_sink (FFT=4, 16-word frames). A frame-level reference
// model (queue of buffered frames, list of words of the open frame) is
// stepped on every clock edge and all outputs are compared one time unit
// later. Directed sections pin the model with hand-computed values; a
// randomized section mixes good, short, long, unterminated and orphan frames.
module tb_pr3_frame_sink;
  localparam int FFT = 4;
  localparam int LEN = 16;

  logic        clk40 = 1'b0;
  logic        reset_n = 1'b0;
  logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic [31:0] sink_data = 32'd0;
  logic        frame_ready, frame_ack = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [31:0] rd_data;
  logic [15:0] frame_count, err_count;
  logic        overrun;
`ifdef PR3_SINK_PEAK_EN
  logic [3:0]  peak_index;
  logic [31:0] peak_value;
`endif

  pr3_frame_sink #(.FFT(FFT), .DW(32), .CW(16)) dut (
    .clk40(clk40), .reset_n(reset_n),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_data(sink_data),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_count(frame_count), .err_count(err_count), .overrun(overrun)
`ifdef PR3_SINK_PEAK_EN
    , .peak_index(peak_index), .peak_value(peak_value)
`endif
  );

  always #5 clk40 = ~clk40;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode;       // 0 waiting for sop, 1 collecting, 2 discarding
  logic [31:0] m_cur[$];     // words of the open frame
  logic [LEN*32-1:0] m_fq[$];// buffered frames, oldest first
  int          m_fc, m_ec;
  bit          m_ovr;

  task automatic model_reset();
    m_mode = 0; m_cur.delete(); m_fq.delete();
    m_fc = 0; m_ec = 0; m_ovr = 1'b0;
  endtask

  // Model and compare, one step per clock edge.
  always @(posedge clk40) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      bit rd_ok, err, commit, pop;
      logic [31:0] exp_rd;
      logic [LEN*32-1:0] f;
      rd_ok = (m_fq.size() > 0);
      exp_rd = rd_ok ? m_fq[0][rd_addr*32 +: 32] : 32'd0;
      pop = frame_ack && (m_fq.size() > 0);
      err = 1'b0; commit = 1'b0;
      if (sink_valid) begin
        if (sink_sop) begin
          if (m_mode == 1) err = 1'b1;
          if (m_fq.size() == 2) begin
            err = 1'b1; m_ovr = 1'b1; m_mode = sink_eop ? 0 : 2;
          end else if (sink_eop) begin
            err = 1'b1; m_mode = 0;
          end else begin
            m_cur.delete(); m_cur.push_back(sink_data); m_mode = 1;
          end
        end else if (m_mode == 0) begin
          err = 1'b1;
        end else if (m_mode == 1) begin
          if (sink_eop) begin
            if (m_cur.size() == LEN - 1) begin
              m_cur.push_back(sink_data); commit = 1'b1;
            end else begin
              err = 1'b1;
            end
            m_mode = 0;
          end else if (m_cur.size() == LEN - 1) begin
            err = 1'b1; m_mode = 2;
          end else begin
            m_cur.push_back(sink_data);
          end
        end else if (sink_eop) begin
          m_mode = 0;
        end
      end
      if (pop) void'(m_fq.pop_front());
      if (commit) begin
        for (int i = 0; i < LEN; i++) f[i*32 +: 32] = m_cur[i];
        m_fq.push_back(f);
        m_fc = (m_fc + 1) % 65536;
      end
      if (err && m_ec != 65535) m_ec++;
      #1;
      chk("frame_ready", frame_ready, m_fq.size() > 0);
      chk("frame_count", frame_count, m_fc);
      chk("err_count", err_count, m_ec);
      chk("overrun", overrun, m_ovr);
      if (rd_ok) chk("rd_data", rd_data, exp_rd);
    end
  end

  // ---------------- stimulus ----------------
  int ack_pct = 0;
  int gap_pct = 0;
  bit rand_addr = 1'b0;

  task automatic send(input bit v, input bit s, input bit e, input logic [31:0] d, input bit ack);
    sink_valid = v; sink_sop = s; sink_eop = e; sink_data = d;
    frame_ack = ack | (32'($urandom_range(99)) < 32'(ack_pct));
    if (rand_addr) rd_addr = 4'($urandom);
    @(negedge clk40);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // n words, sop on word 0, eop on word eop_at (-1: none), data = base + i.
  task automatic frame(input int n, input int eop_at, input logic [31:0] base, input bit ack_eop);
    for (int i = 0; i < n; i++) begin
      if (32'($urandom_range(99)) < 32'(gap_pct))
        send(1'b0, 1'($urandom), 1'($urandom), $urandom, 1'b0);
      send(1'b1, i == 0, i == eop_at, base + 32'(i), ack_eop && (i == eop_at));
    end
  endtask

  task automatic do_reset();
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; frame_ack = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst frame_ready", frame_ready, 1'b0);
    chk("rst frame_count", frame_count, 16'd0);
    chk("rst err_count", err_count, 16'd0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst rd_data", rd_data, 32'd0);
    @(negedge clk40); @(negedge clk40);
    reset_n = 1'b1;
    @(negedge clk40);
  endtask

  initial begin
    @(negedge clk40);
    do_reset();

    // Clean frame, then registered read of word 5.
    frame(16, 15, 32'd0, 1'b0);
    rd_addr = 4'd5;
    idle(1);
    chk("clean frame_ready", frame_ready, 1'b1);
    chk("clean rd_data", rd_data, 32'd5);
    chk("clean frame_count", frame_count, 16'd1);
    send(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(1);
    chk("acked frame_ready", frame_ready, 1'b0);

    // Reset in the middle of a frame, then framing errors.
    frame(8, -1, 32'h50, 1'b0);
    do_reset();
    frame(11, 10, 32'h60, 1'b0);   // short
    frame(17, 16, 32'h70, 1'b0);   // long, eop ends the discard
    send(1'b1, 1'b0, 1'b0, 32'h99, 1'b0); // orphan
    idle(1);
    chk("framing err_count", err_count, 16'd3);
    chk("framing frame_count", frame_count, 16'd0);
    frame(16, 15, 32'h80, 1'b0);
    idle(1);
    chk("after err frame_count", frame_count, 16'd1);

    // Overrun: three frames without ack.
    do_reset();
    frame(16, 15, 32'h100, 1'b0);
    frame(16, 15, 32'h200, 1'b0);
    frame(16, 15, 32'h300, 1'b0);
    rd_addr = 4'd3;
    idle(1);
    chk("ovr overrun", overrun, 1'b1);
    chk("ovr err_count", err_count, 16'd1);
    chk("ovr frame_count", frame_count, 16'd2);
    chk("ovr first rd_data", rd_data, 32'h103);
    send(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(1);
    chk("ovr second rd_data", rd_data, 32'h203);

    // Back-to-back frames, ack on each commit cycle.
    do_reset();
    for (int k = 0; k < 6; k++) frame(16, 15, 32'(k) << 8, 1'b1);
    idle(1);
    chk("b2b overrun", overrun, 1'b0);
    chk("b2b frame_count", frame_count, 16'd6);
    chk("b2b err_count", err_count, 16'd0);
    chk("b2b last frame", rd_data[31:8], 24'd5);

`ifdef PR3_SINK_PEAK_EN
    do_reset();
    for (int i = 0; i < 16; i++)
      send(1'b1, i == 0, i == 15, (i == 7 || i == 12) ? 32'h1234 : 32'(i), 1'b0);
    idle(1);
    chk("peak_index", peak_index, 4'd7);
    chk("peak_value", peak_value, 32'h1234);
`endif

    // Randomized mix of frame shapes with random ack, gaps and read addresses.
    do_reset();
    ack_pct = 30; gap_pct = 15; rand_addr = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int kind, n;
      kind = int'($urandom_range(9));
      if (kind < 6) begin
        frame(16, 15, $urandom, 1'b0);
      end else if (kind == 6) begin
        n = int'($urandom_range(15, 1));
        frame(n, n - 1, $urandom, 1'b0);
      end else if (kind == 7) begin
        n = int'($urandom_range(20, 17));
        frame(n, n - 1, $urandom, 1'b0);
      end else if (kind == 8) begin
        frame(int'($urandom_range(10, 3)), -1, $urandom, 1'b0);
      end else begin
        send(1'b1, 1'b0, 1'($urandom), $urandom, 1'b0);
      end
    end
    ack_pct = 100;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
